// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU LSB first and assembles the word result and flags.
// Optional SLT support (op 0111) is enabled by defining ALU_SEQ_SLT_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             op_err,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int unsigned   CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [3:0]    OP_AND = 4'b0000;
  localparam logic [3:0]    OP_OR  = 4'b0001;
  localparam logic [3:0]    OP_ADD = 4'b0010;
  localparam logic [3:0]    OP_SUB = 4'b0110;
  localparam logic [3:0]    OP_SLT = 4'b0111;
  localparam logic [3:0]    OP_NOR = 4'b1100;

`ifdef ALU_SEQ_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry_q;
  logic             accept, op_ok, last_bit;
  logic [WIDTH-1:0] res_full, res_fin;
  logic             cout_fin, ovf_fin;

  // Operand shifters present the current bit at position 0 and drain to zero by the end of RUN.
  assign alu_a   = a_sh[0];
  assign alu_b   = b_sh[0];
  assign alu_cin = carry_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, start decode and final result/flag assembly from the last bit slice.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    op_ok    = 1'b0;
    last_bit = 1'b0;
    res_full = {alu_result, res_sh[WIDTH-1:1]};
    res_fin  = res_full;
    cout_fin = 1'b0;
    ovf_fin  = 1'b0;

    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_ok = 1'b1;
      OP_SLT:  op_ok = SLT_EN;
      default: op_ok = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = op_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // op bit 1 marks the carry-chain ops (ADD, SUB, SLT)
    if (op_q_arith()) begin
      cout_fin = alu_cout;
      ovf_fin  = carry_q ^ alu_cout;
    end
    if (alu_op == OP_SLT) begin
      res_fin  = WIDTH'(res_full[WIDTH-1] ^ carry_q ^ alu_cout);
      cout_fin = 1'b0;
      ovf_fin  = 1'b0;
    end
  end

  function automatic logic op_q_arith();
    return alu_op[1];
  endfunction

  // Datapath, handshake and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      op_err    <= 1'b0;
      alu_op    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      if (accept) begin
        cnt_q <= '0;
        if (op_ok) begin
          a_sh    <= a;
          b_sh    <= b;
          alu_op  <= op;
          carry_q <= op[2] & op[1];
          op_err  <= 1'b0;
        end else begin
          result    <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b1;
          op_err    <= 1'b1;
        end
      end else if (state_q == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        res_sh  <= res_full;
        cnt_q   <= cnt_q + CW'(1);
        carry_q <= alu_op[1] ? alu_cout : 1'b0;
        if (last_bit) begin
          alu_op    <= '0;
          carry_q   <= 1'b0;
          result    <= res_fin;
          carry_out <= cout_fin;
          overflow  <= ovf_fin;
          zero      <= (res_fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: behavioural 1-bit ALU, word-level reference model, decoupled done monitor.
module tb_alu_serial_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, overflow, zero, op_err;
  logic [W-1:0] result;
  logic         alu_a, alu_b, alu_cin, alu_result, alu_cout;
  logic [3:0]   alu_op;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zr;
    logic         err;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .op_err(op_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External 1-bit ALU slice
  logic nb;
  always_comb begin
    nb         = ~alu_b;
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b0010: {alu_cout, alu_result} = 2'(alu_a) + 2'(alu_b) + 2'(alu_cin);
      4'b0110, 4'b0111: {alu_cout, alu_result} = 2'(alu_a) + 2'(nb) + 2'(alu_cin);
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_arith(input logic [3:0] o);
`ifdef ALU_SEQ_SLT_EN
    return (o == 4'b0010) || (o == 4'b0110) || (o == 4'b0111);
`else
    return (o == 4'b0010) || (o == 4'b0110);
`endif
  endfunction

  // Word-level reference computed with plain integer arithmetic
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx, sy, sr;
    int unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.done_cyc = 0;
    case (o)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b1100: e.res = ~(x | y);
      4'b0010: begin
        e.res  = W'(ux + uy);
        e.cout = (ux + uy) >= (1 << W);
        sr     = sx + sy;
        e.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      end
      4'b0110: begin
        e.res  = W'(ux - uy);
        e.cout = (ux >= uy);
        sr     = sx - sy;
        e.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      end
`ifdef ALU_SEQ_SLT_EN
      4'b0111: e.res = (sx < sy) ? W'(1) : W'(0);
`endif
      default: e.err = 1'b1;
    endcase
    e.zr = (e.res == '0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("result",     64'(result), 64'(e.res));
        check("carry_out",  64'(carry_out), 64'(e.cout));
        check("overflow",   64'(overflow), 64'(e.ovf));
        check("zero",       64'(zero), 64'(e.zr));
        check("op_err",     64'(op_err), 64'(e.err));
      end
    end
  end

  task automatic check_idle_alu(input string tag);
    check({tag, "_alu_bus"}, 64'({alu_a, alu_b, alu_cin, alu_op}), 64'(0));
  endtask

  // Issue one operation, check every bit slice, then confirm results hold in IDLE.
  // Called and returns just after a rising edge (+1).
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    int          n;
    int unsigned yy, cin0, ck;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    if (busy) begin
      check("idle_timeout", 64'(busy), 64'(0));
      return;
    end
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    e = model(o, x, y);
    // done is visible in the cycle ending WIDTH+1 edges (legal) or 1 edge (illegal) after acceptance
    e.done_cyc = cyc + (e.err ? 0 : int'(W));
    q.push_back(e);
    if (!e.err) begin
      cin0 = (o == 4'b0010) ? 0 : 1;
      yy   = (o == 4'b0010) ? int'(y) : int'(W'(~y));
      for (int k = 0; k < int'(W); k++) begin
        check("busy_run", 64'(busy), 64'(1));
        check("alu_a",  64'(alu_a), 64'(x[k]));
        check("alu_b",  64'(alu_b), 64'(y[k]));
        check("alu_op", 64'(alu_op), 64'(o));
        if (is_arith(o)) begin
          ck = (((int'(x) & ((1 << k) - 1)) + (yy & ((1 << k) - 1)) + cin0) >> k) & 1;
          check("alu_cin", 64'(alu_cin), 64'(ck));
        end else begin
          check("alu_cin_logic", 64'(alu_cin), 64'(0));
        end
        @(posedge clk); #1;
      end
    end
    n = 0;
    while (busy && n < 10) begin @(posedge clk); #1; n++; end
    check("busy_after_done", 64'(busy), 64'(0));
    check_idle_alu("idle");
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    check("result_held", 64'({result, carry_out, overflow, zero, op_err}),
          64'({e.res, e.cout, e.ovf, e.zr, e.err}));
  endtask

  initial begin
    logic [3:0] legal_ops [6];
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({busy, done, result, carry_out, overflow, zero, op_err}),
          64'({1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0}));
    check_idle_alu("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'b0010, 8'h7F, 8'h01);
    run_op(4'b0110, 8'h05, 8'h05);
    run_op(4'b1100, 8'hF0, 8'h0C);
    run_op(4'b1111, 8'h12, 8'h34);
    run_op(4'b0000, 8'hAA, 8'h0F);
    run_op(4'b0111, 8'hFE, 8'h01);
    run_op(4'b0110, 8'h00, 8'h01);
    run_op(4'b0010, 8'hFF, 8'h01);

    // Abort: restart attempt in RUN cycle 3, reset in RUN cycle 5, no done expected
    start = 1'b1; op = 4'b0010; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; op = 4'b0110; a = 8'h55; b = 8'h66;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_still_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_reset_state", 64'({busy, done, result, carry_out, overflow, zero, op_err}),
          64'({1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b1, 1'b0}));
    check_idle_alu("abort");
    repeat (W + 4) begin @(posedge clk); #1; end
    check("abort_no_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 40; i++) begin
      logic [3:0] o;
      o = (i % 2 == 0) ? legal_ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      run_op(o, W'($urandom), W'($urandom));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected end before 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
